// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one sequential Booth multiplier among
// N_REQ requesters: grant, clear, start, wait under a watchdog, then respond.
module booth_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]     rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   mul_rst,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_m,
    output logic [WIDTH-1:0]       mul_q,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_p
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      win_q, win_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]   op_m_q, op_m_d;
    logic [WIDTH-1:0]   op_q_q, op_q_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0]   a_arr [N_REQ];
    logic [WIDTH-1:0]   b_arr [N_REQ];
    logic               found;
    logic [PW-1:0]      win_sel;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    // First asserted request found walking upward from ptr, wrapping around.
    always_comb begin
        int idx;
        found   = 1'b0;
        win_sel = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx[PW-1:0]]) begin
                found   = 1'b1;
                win_sel = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        gnt_d      = gnt_q;
        op_m_d     = op_m_q;
        op_q_d     = op_q_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d          = win_sel;
                    op_m_d         = a_arr[win_sel];
                    op_q_d         = b_arr[win_sel];
                    gnt_d          = '0;
                    gnt_d[win_sel] = 1'b1;
                    state_d        = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                state_d = WAIT;
            end
            // Done wins over the watchdog when both land in the same cycle.
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mul_done) begin
                    rsp_data_d = mul_p;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                ptr_d     = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;
                gnt_d     = '0;
                rsp_err_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            gnt_q      <= '0;
            op_m_q     <= '0;
            op_q_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            gnt_q      <= gnt_d;
            op_m_q     <= op_m_d;
            op_q_q     <= op_q_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = (state_q == RESP) ? gnt_q : '0;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign mul_rst   = rst | (state_q == CLR);
    assign mul_start = (state_q == START);
    assign mul_m     = op_m_q;
    assign mul_q     = op_q_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: a transaction-level model predicts the control outputs
// every cycle while directed tables, corner sequences and random traffic drive the arbiter.
`timescale 1ns/1ps
module tb_booth_mul_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] reqA, reqB;
    logic [N-1:0]   gnt, rspValid;
    logic [2*W-1:0] rspData;
    logic           rspErr, busy, mulRst, mulStart;
    logic [W-1:0]   mulM, mulQ;
    logic           mulDone;
    logic [2*W-1:0] mulP;

    int vectors     = 0;
    int miscompares = 0;

    booth_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(reqA), .req_b(reqB),
        .gnt(gnt), .rsp_valid(rspValid), .rsp_data(rspData), .rsp_err(rspErr),
        .busy(busy), .mul_rst(mulRst), .mul_start(mulStart), .mul_m(mulM),
        .mul_q(mulQ), .mul_done(mulDone), .mul_p(mulP)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] signedProduct(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0]   sa;
        logic signed [W-1:0]   sb;
        logic signed [2*W-1:0] p;
        sa = a;
        sb = b;
        p  = sa * sb;
        return p;
    endfunction

    function automatic logic [N-1:0] oneHot(input int i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Multiplier stand-in: product after mulLat cycles (never if mulLat < 1), done held until cleared.
    int             mulLat = 8;
    logic           presetDone;
    logic           stubDone, stubRun;
    int             stubCnt;
    logic [2*W-1:0] stubP;
    assign mulDone = stubDone;
    assign mulP    = stubP;

    always @(posedge clk) begin
        if (mulRst) begin
            stubDone <= 1'b0;
            stubRun  <= 1'b0;
            stubCnt  <= 0;
        end else if (mulStart) begin
            stubRun <= (mulLat > 0);
            stubCnt <= mulLat;
            stubP   <= signedProduct(mulM, mulQ);
        end else if (presetDone) begin
            stubDone <= 1'b1;
        end else if (stubRun) begin
            if (stubCnt <= 1) begin
                stubDone <= 1'b1;
                stubRun  <= 1'b0;
            end else begin
                stubCnt <= stubCnt - 1;
            end
        end
    end

    // Reference: one operation spans sample cycle s to s+respK, respK derived from latency and watchdog.
    bit             modelValid = 0;
    bit             mIdle      = 1;
    bit             mJustReset = 0;
    int             mK, mWin, mRespK;
    int             mPtr = 0;
    logic [W-1:0]   mOpA, mOpB;
    logic [2*W-1:0] mProd;
    logic           mErr;

    always @(negedge clk) begin
        logic [N-1:0] eGnt;
        logic [N-1:0] eValid;
        logic         eRst, eStart;
        int           lat;
        bit           hit;
        if (modelValid) begin
            eGnt   = mIdle ? '0 : oneHot(mWin);
            eValid = (!mIdle && mK == mRespK) ? oneHot(mWin) : '0;
            eRst   = rst | (!mIdle && mK == 1);
            eStart = !mIdle && mK == 2;
            checkOutput("ctl{gnt,valid,busy,mulRst,mulStart,m,q}",
                        {gnt, rspValid, busy, mulRst, mulStart, mulM, mulQ},
                        {eGnt, eValid, !mIdle, eRst, eStart, mOpA, mOpB});
            if (eValid != '0) begin
                checkOutput("rspData", rspData, mProd);
                checkOutput("rspErr", rspErr, mErr);
            end
            if (mJustReset) begin
                checkOutput("rstRspData", rspData, '0);
                checkOutput("rstRspErr", rspErr, 1'b0);
            end
        end
        if (rst) begin
            modelValid = 1;
            mJustReset = 1;
            mIdle      = 1;
            mPtr       = 0;
            mOpA       = '0;
            mOpB       = '0;
        end else begin
            mJustReset = 0;
            if (mIdle) begin
                if (req != '0) begin
                    hit = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!hit && req[(mPtr + k) % N]) begin
                            hit  = 1;
                            mWin = (mPtr + k) % N;
                        end
                    end
                    mOpA = reqA[mWin*W +: W];
                    mOpB = reqB[mWin*W +: W];
                    lat  = mulLat;
                    if (lat >= 1 && lat <= TO - 1) begin
                        mRespK = 4 + lat;
                        mErr   = 1'b0;
                        mProd  = signedProduct(mOpA, mOpB);
                    end else begin
                        mRespK = 3 + TO;
                        mErr   = 1'b1;
                        mProd  = '0;
                    end
                    mK    = 1;
                    mIdle = 0;
                end
            end else if (mK == mRespK) begin
                mIdle = 1;
                mPtr  = (mWin + 1) % N;
            end else begin
                mK++;
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        req  = r;
        reqA = a;
        reqB = b;
        nextCycle();
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!mIdle && n < 300) begin
            nextCycle();
            n++;
        end
        if (!mIdle) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idleWait: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic waitResponse(output int idx, output logic [2*W-1:0] d, output logic e, output bit ok);
        ok  = 0;
        idx = -1;
        d   = '0;
        e   = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (rspValid != '0) begin
                ok = 1;
                d  = rspData;
                e  = rspErr;
                for (int k = 0; k < N; k++) begin
                    if (rspValid[k]) idx = k;
                end
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rspWait: no rsp_valid within 200 cycles, required one");
        end
        nextCycle();
    endtask

    typedef struct {
        int             idx;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             lat;
        logic [2*W-1:0] expData;
        logic           expErr;
    } vec_t;

    vec_t           tbl [8];
    int             rrOrder [5];
    logic [2*W-1:0] rrData [5];
    int             gotIdx;
    logic [2*W-1:0] gotData;
    logic           gotErr;
    bit             ok;
    logic [N*W-1:0] aVec, bVec;
    logic [31:0]    r32;

    initial begin
        tbl[0] = '{0, 8'h07, 8'hFD, 8,  16'hFFEB, 1'b0};
        tbl[1] = '{2, 8'h80, 8'h80, 5,  16'h4000, 1'b0};
        tbl[2] = '{3, 8'h7F, 8'h80, 1,  16'hC080, 1'b0};
        tbl[3] = '{1, 8'h00, 8'h37, 2,  16'h0000, 1'b0};
        tbl[4] = '{1, 8'hFF, 8'hFF, 63, 16'h0001, 1'b0};
        tbl[5] = '{2, 8'h03, 8'h04, 64, 16'h0000, 1'b1};
        tbl[6] = '{0, 8'h05, 8'h06, -1, 16'h0000, 1'b1};
        tbl[7] = '{3, 8'hFF, 8'h01, 3,  16'hFFFF, 1'b0};
        rrOrder = '{0, 1, 2, 3, 0};
        rrData  = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd2};

        rst = 1'b1; req = '0; reqA = '0; reqB = '0; presetDone = 1'b0;
        nextCycle();
        nextCycle();
        rst = 1'b0;

        $display("[TB] single-requester table");
        for (int i = 0; i < 8; i++) begin
            waitIdle();
            mulLat = tbl[i].lat;
            aVec = '0;
            bVec = '0;
            aVec[tbl[i].idx*W +: W] = tbl[i].a;
            bVec[tbl[i].idx*W +: W] = tbl[i].b;
            applyStimulus(oneHot(tbl[i].idx), aVec, bVec);
            req = '0;
            waitResponse(gotIdx, gotData, gotErr, ok);
            if (ok) begin
                checkOutput("tblIdx", gotIdx, tbl[i].idx);
                checkOutput("tblData", gotData, tbl[i].expData);
                checkOutput("tblErr", gotErr, tbl[i].expErr);
            end
        end

        $display("[TB] all requesters from reset");
        waitIdle();
        mulLat = 3;
        rst  = 1'b1;
        req  = '1;
        reqA = {8'd4, 8'd3, 8'd2, 8'd1};
        reqB = {4{8'd2}};
        nextCycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            waitResponse(gotIdx, gotData, gotErr, ok);
            if (ok) begin
                checkOutput("rrIdx", gotIdx, rrOrder[i]);
                checkOutput("rrData", gotData, rrData[i]);
            end
            if (i == 4) req = '0;
        end

        $display("[TB] simultaneous 1010 with ptr at 2");
        waitIdle();
        mulLat = 2;
        applyStimulus(4'b0010, {8'd0, 8'd0, 8'd3, 8'd0}, {8'd0, 8'd0, 8'd5, 8'd0});
        req = '0;
        waitResponse(gotIdx, gotData, gotErr, ok);
        if (ok) checkOutput("ptrSetupData", gotData, 16'd15);
        req  = 4'b1010;
        reqA = {8'hFE, 8'd0, 8'd6, 8'd0};
        reqB = {8'd7, 8'd0, 8'hFB, 8'd0};
        waitResponse(gotIdx, gotData, gotErr, ok);
        if (ok) begin
            checkOutput("pairFirstIdx", gotIdx, 3);
            checkOutput("pairFirstData", gotData, 16'hFFF2);
        end
        waitResponse(gotIdx, gotData, gotErr, ok);
        if (ok) begin
            checkOutput("pairSecondIdx", gotIdx, 1);
            checkOutput("pairSecondData", gotData, 16'hFFE2);
        end
        req = '0;

        $display("[TB] reset during WAIT, then stale done");
        waitIdle();
        mulLat = 20;
        applyStimulus(4'b0100, {8'd0, 8'd9, 8'd0, 8'd0}, {8'd0, 8'd9, 8'd0, 8'd0});
        req = '0;
        repeat (5) nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        presetDone = 1'b1;
        nextCycle();
        presetDone = 1'b0;
        mulLat = 4;
        applyStimulus(4'b0110, {8'd0, 8'd2, 8'hF9, 8'd0}, {8'd0, 8'd3, 8'd9, 8'd0});
        req = '0;
        waitResponse(gotIdx, gotData, gotErr, ok);
        if (ok) begin
            checkOutput("postRstIdx", gotIdx, 1);
            checkOutput("postRstData", gotData, 16'hFFC1);
            checkOutput("postRstErr", gotErr, 1'b0);
        end

        $display("[TB] operand change and req drop after grant");
        waitIdle();
        mulLat = 6;
        applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd5}, {8'd0, 8'd0, 8'd0, 8'hFC});
        nextCycle();
        reqA[7:0] = 8'd9;
        req = '0;
        waitResponse(gotIdx, gotData, gotErr, ok);
        if (ok) begin
            checkOutput("dropIdx", gotIdx, 0);
            checkOutput("dropData", gotData, 16'hFFEC);
        end

        $display("[TB] random traffic");
        waitIdle();
        for (int c = 0; c < 400; c++) begin
            if (mIdle) begin
                mulLat = ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(1, 24));
            end
            r32  = $urandom;
            req  = ($urandom_range(0, 2) == 0) ? '0 : r32[N-1:0];
            reqA = $urandom;
            reqB = $urandom;
            rst  = ($urandom_range(0, 149) == 0);
            nextCycle();
        end
        rst = 1'b0;
        req = '0;
        waitIdle();
        repeat (3) nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL globalTimeout: simulation exceeded time limit");
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one sequential Booth multiplier (radix-2, shift/add controller plus datapath) among N_REQ requesters in the DCT datapath. It performs the following steps for each operation:

- grants one requester and latches its operands;
- re-arms the multiplier with a clear pulse, then pulses start;
- waits for done, with a watchdog;
- returns the signed product to the winning requester with a one-cycle valid strobe.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width in bits, two's complement
- TIMEOUT, 64, maximum cycles spent in WAIT before the operation is aborted (must be > 2*WIDTH+4)
- clk  input  1  clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- req  input  N_REQ  per-requester request level
- req_a  input  N_REQ*WIDTH  multiplicand M of requester i in bits [i*WIDTH +: WIDTH]
- req_b  input  N_REQ*WIDTH  multiplier Q of requester i, same packing
- gnt  output  N_REQ  one-hot grant, held high from grant through the response cycle
- rsp_valid  output  N_REQ  one-cycle strobe at the granted index
- rsp_data  output  2*WIDTH  product; valid only while any rsp_valid bit is high
- rsp_err  output  1  high with rsp_valid when the watchdog aborted the operation
- busy  output  1  high in every state except IDLE
- mul_rst  output  1  synchronous clear to the multiplier controller and datapath
- mul_start  output  1  start pulse to the multiplier
- mul_m  output  WIDTH  latched multiplicand to the multiplier
- mul_q  output  WIDTH  latched multiplier to the multiplier
- mul_done  input  1  multiplier done level; stays high in its terminal state until cleared
- mul_p  input  2*WIDTH  multiplier product, concatenation {A,Q}

## Operation
- FSM states: IDLE, CLR, START, WAIT, RESP. All outputs are registered or decoded from state.
- Round-robin pointer `ptr` (log2 N_REQ bits) holds the highest-priority index. The search order is ptr, ptr+1, ..., wrapping modulo N_REQ.
- IDLE:
  - If req != 0, select the first asserted index in search order as `win`.
  - Latch req_a[win] into mul_m and req_b[win] into mul_q.
  - Set gnt = onehot(win) and go to CLR.
  - Otherwise stay in IDLE.
- CLR: mul_rst = 1 for exactly one cycle. This forces the multiplier out of its terminal state. Clear the watchdog counter. Go to START.
- START: mul_start = 1 for exactly one cycle. Go to WAIT.
- WAIT:
  - The watchdog counter increments each cycle.
  - If mul_done == 1: latch mul_p into rsp_data, set rsp_err = 0, go to RESP.
  - Otherwise, if the counter reaches TIMEOUT-1: set rsp_data = 0, rsp_err = 1, go to RESP.
  - mul_done takes priority when both conditions occur in the same cycle.
- RESP:
  - Assert rsp_valid[win] for one cycle.
  - Set ptr = (win+1) mod N_REQ.
  - Clear gnt at the exit edge and go to IDLE.
- Operands are captured at grant. Requesters may change req_a/req_b after gnt rises.
- A requester that keeps req high after its rsp_valid is treated as a new request and competes in the next IDLE cycle. Round-robin order prevents starvation.
- If req[win] drops while granted, it is ignored: the operation completes and rsp_valid still pulses.
- mul_done is sampled only in WAIT. A stale done level in IDLE, CLR or START has no effect.
- mul_rst = rst OR (state == CLR).

## Timing
- Reset (rst high at an edge, from any state):
  - state = IDLE, ptr = 0;
  - gnt, rsp_valid, rsp_err, busy, mul_start = 0;
  - mul_m, mul_q, rsp_data = 0;
  - mul_rst is high while rst is high.
- Reset mid-operation discards the in-flight operation with no rsp_valid.
- The arbiter samples req in IDLE cycle t. Then:
  - gnt and busy rise at t+1;
  - mul_rst is high in cycle t+1 (CLR);
  - mul_start is high in cycle t+2 (START);
  - WAIT starts at t+3.
- If mul_done is first seen high in WAIT cycle w, rsp_valid and rsp_data appear in cycle w+1 (RESP). IDLE follows at w+2.
- Overhead is 4 cycles plus the multiplier latency. A back-to-back grant can occur at w+3.
- A timeout produces rsp_valid with rsp_err = 1 exactly TIMEOUT cycles after WAIT entry.

## Test plan
- Single request: N_REQ=4, WIDTH=8, req=0001, a=7, b=-3. Required: gnt=0001 for the whole operation, one mul_rst pulse, one mul_start pulse, rsp_valid=0001, rsp_data=16'hFFEB (-21), rsp_err=0.
- All requesters high continuously from reset, a=i+1, b=2. Required: grant order 0,1,2,3,0, products 2,4,6,8,2, each index's rsp_valid strobing exactly once per round.
- Simultaneous req=1010 with ptr=2. Required: index 3 granted first, then index 1. A grant to index 3 leaves ptr=0.
- Watchdog: a multiplier model that never raises done. Required: rsp_valid at the granted index TIMEOUT cycles after WAIT entry, rsp_err=1, rsp_data=0, then IDLE.
- rst asserted during WAIT. Required: next cycle busy=0 and gnt=0, no rsp_valid, ptr=0. A fresh request afterwards completes correctly, with mul_done left high from the prior operation ignored until after CLR.
- Operand change and req drop after grant: requester 0 changes req_a from 5 to 9 and drops req one cycle after gnt. Required: product uses 5, and rsp_valid[0] still pulses.
